// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core.
// Resolves data-memory wait, taken branch, load-use hazard and fetch wait
// by fixed priority, sequences multi-cycle IF/ID flushes after a taken
// branch and keeps saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [REG_ADDR_WIDTH-1:0] i_idRs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_idRs2,
  input  logic                      i_idUseRs1,
  input  logic                      i_idUseRs2,
  input  logic [REG_ADDR_WIDTH-1:0] i_exRd,
  input  logic                      i_exIsLoad,
  input  logic                      i_exRegWe,
  input  logic                      i_exBranchTaken,
  input  logic                      i_ifBusy,
  input  logic                      i_memBusy,
  output logic                      o_stallPC,
  output logic                      o_stallIFID,
  output logic                      o_stallIDEX,
  output logic                      o_stallEXMEM,
  output logic                      o_flushIFID,
  output logic                      o_flushIDEX,
  output logic [1:0]                o_state,
  output logic [CNT_WIDTH-1:0]      o_stallCount,
  output logic [CNT_WIDTH-1:0]      o_flushCount
);

  localparam int unsigned         FCNT_W      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCNT_W-1:0]   FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FCNT_W-1:0]   FCNT_ONE    = FCNT_W'(1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FLUSH      = 2'd2,
    LOAD_STALL = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;
  logic                  hz;
  logic                  any_stall;
  logic                  br_accept;

  // Load in EX whose destination (not x0) is read by the ID instruction.
  assign hz = i_exIsLoad & i_exRegWe & (i_exRd != '0) &
              ((i_idUseRs1 & (i_idRs1 == i_exRd)) |
               (i_idUseRs2 & (i_idRs2 == i_exRd)));

  // State, flush counter and performance counter registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state selection by rule priority; the flush sequence is tracked by
  // fcnt so a memory wait in the middle of it keeps the remaining count.
  always_comb begin
    state_d   = RUN;
    fcnt_d    = fcnt_q;
    br_accept = 1'b0;
    if (i_memBusy) begin
      state_d = MEM_WAIT;
    end else if (i_exBranchTaken) begin
      br_accept = 1'b1;
      fcnt_d    = FCNT_RELOAD;
      state_d   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (fcnt_q != '0) begin
      fcnt_d  = fcnt_q - FCNT_ONE;
      state_d = (fcnt_q == FCNT_ONE) ? RUN : FLUSH;
    end else if (hz) begin
      state_d = LOAD_STALL;
    end else begin
      state_d = RUN;
    end

    stall_cnt_d = stall_cnt_q;
    if (any_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (br_accept && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Stall/flush outputs from current inputs and registered flush count.
  always_comb begin
    o_stallPC    = 1'b0;
    o_stallIFID  = 1'b0;
    o_stallIDEX  = 1'b0;
    o_stallEXMEM = 1'b0;
    o_flushIFID  = 1'b0;
    o_flushIDEX  = 1'b0;
    if (i_reset) begin
      o_flushIFID = 1'b1;
      o_flushIDEX = 1'b1;
    end else if (i_memBusy) begin
      o_stallPC    = 1'b1;
      o_stallIFID  = 1'b1;
      o_stallIDEX  = 1'b1;
      o_stallEXMEM = 1'b1;
    end else if (i_exBranchTaken) begin
      o_flushIFID = 1'b1;
      o_flushIDEX = 1'b1;
    end else if (fcnt_q != '0) begin
      o_flushIFID = 1'b1;
    end else if (hz) begin
      o_stallPC   = 1'b1;
      o_stallIFID = 1'b1;
      o_flushIDEX = 1'b1;
    end else if (i_ifBusy) begin
      o_stallPC   = 1'b1;
      o_flushIFID = 1'b1;
    end
  end

  assign any_stall    = o_stallPC | o_stallIFID | o_stallIDEX | o_stallEXMEM;
  assign o_state      = state_q;
  assign o_stallCount = stall_cnt_q;
  assign o_flushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (3- and 4-cycle flush, the
// second with a 3-bit counter to reach saturation), a vector table, directed
// multi-cycle sequences and a random run against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RAW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, mem, br, ifb, ld, we, u1, u2;
  logic [RAW-1:0] rd, rs1, rs2;

  logic        a_spc, a_sifid, a_sidex, a_sexmem, a_fifid, a_fidex;
  logic        b_spc, b_sifid, b_sidex, b_sexmem, b_fifid, b_fidex;
  logic [1:0]  a_state, b_state;
  logic [31:0] a_sc, a_fc;
  logic [2:0]  b_sc, b_fc;
  logic [5:0]  a_out, b_out;

  assign a_out = {a_spc, a_sifid, a_sidex, a_sexmem, a_fifid, a_fidex};
  assign b_out = {b_spc, b_sifid, b_sidex, b_sexmem, b_fifid, b_fidex};

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .FLUSH_CYCLES(3), .CNT_WIDTH(32)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_idRs1(rs1), .i_idRs2(rs2),
    .i_idUseRs1(u1), .i_idUseRs2(u2), .i_exRd(rd), .i_exIsLoad(ld),
    .i_exRegWe(we), .i_exBranchTaken(br), .i_ifBusy(ifb), .i_memBusy(mem),
    .o_stallPC(a_spc), .o_stallIFID(a_sifid), .o_stallIDEX(a_sidex),
    .o_stallEXMEM(a_sexmem), .o_flushIFID(a_fifid), .o_flushIDEX(a_fidex),
    .o_state(a_state), .o_stallCount(a_sc), .o_flushCount(a_fc));

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .FLUSH_CYCLES(4), .CNT_WIDTH(3)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_idRs1(rs1), .i_idRs2(rs2),
    .i_idUseRs1(u1), .i_idUseRs2(u2), .i_exRd(rd), .i_exIsLoad(ld),
    .i_exRegWe(we), .i_exBranchTaken(br), .i_ifBusy(ifb), .i_memBusy(mem),
    .o_stallPC(b_spc), .o_stallIFID(b_sifid), .o_stallIDEX(b_sidex),
    .o_stallEXMEM(b_sexmem), .o_flushIFID(b_fifid), .o_flushIDEX(b_fidex),
    .o_state(b_state), .o_stallCount(b_sc), .o_flushCount(b_fc));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rule-level reference: remaining flush cycles, state number and event counts.
  int               m_st  [2];
  int               m_rem [2];
  longint unsigned  m_sc  [2];
  longint unsigned  m_fcn [2];
  longint unsigned  cmax  [2];
  int               fcyc  [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_rem[k] = 0; m_sc[k] = 0; m_fcn[k] = 0;
    end
    cmax[0] = 64'hFFFF_FFFF; cmax[1] = 64'd7;
    fcyc[0] = 3;             fcyc[1] = 4;
  end

  always @(negedge clk) begin : model
    logic       hzv;
    logic [5:0] e;
    logic [63:0] act_out, act_st, act_sc, act_fc;
    hzv = ld && we && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    for (int k = 0; k < 2; k++) begin
      act_out = (k == 0) ? 64'(a_out)   : 64'(b_out);
      act_st  = (k == 0) ? 64'(a_state) : 64'(b_state);
      act_sc  = (k == 0) ? 64'(a_sc)    : 64'(b_sc);
      act_fc  = (k == 0) ? 64'(a_fc)    : 64'(b_fc);
      chk("model_state", act_st, 64'(m_st[k]));
      chk("model_stallCount", act_sc, m_sc[k]);
      chk("model_flushCount", act_fc, m_fcn[k]);
      if (rst) begin
        e = 6'b000011;
        m_st[k] = 0; m_rem[k] = 0; m_sc[k] = 0; m_fcn[k] = 0;
      end else begin
        if (mem) begin
          e = 6'b111100; m_st[k] = 1;
        end else if (br) begin
          e = 6'b000011;
          m_rem[k] = fcyc[k] - 1;
          m_st[k]  = (fcyc[k] > 1) ? 2 : 0;
          if (m_fcn[k] < cmax[k]) m_fcn[k]++;
        end else if (m_rem[k] > 0) begin
          e = 6'b000010;
          m_rem[k]--;
          m_st[k] = (m_rem[k] > 0) ? 2 : 0;
        end else if (hzv) begin
          e = 6'b110001; m_st[k] = 3;
        end else if (ifb) begin
          e = 6'b100010; m_st[k] = 0;
        end else begin
          e = 6'b000000; m_st[k] = 0;
        end
        if ((e[5:2] != 4'b0) && (m_sc[k] < cmax[k])) m_sc[k]++;
      end
      chk("model_out", act_out, 64'(e));
    end
  end

  // ctl = {mem, br, ifb, ld, we, u1, u2}; eo = {sPC,sIFID,sIDEX,sEXMEM,fIFID,fIDEX}
  typedef struct packed {
    logic [6:0]     ctl;
    logic [RAW-1:0] rd, rs1, rs2;
    logic [5:0]     eo;
    logic [1:0]     es;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] c, input logic [RAW-1:0] d,
                              input logic [RAW-1:0] s1, input logic [RAW-1:0] s2,
                              input logic [5:0] o, input logic [1:0] s);
    vec_t v;
    v.ctl = c; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.eo = o; v.es = s;
    return v;
  endfunction

  task automatic idle();
    mem = 0; br = 0; ifb = 0; ld = 0; we = 0; u1 = 0; u2 = 0;
    rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1; idle(); nxt(); rst = 0;
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = mk(7'b0000000, 5'd0, 5'd0, 5'd0, 6'b000000, 2'd0);
    tbl[1]  = mk(7'b0001101, 5'd5, 5'd0, 5'd5, 6'b110001, 2'd3);
    tbl[2]  = mk(7'b0001101, 5'd0, 5'd0, 5'd0, 6'b000000, 2'd0);
    tbl[3]  = mk(7'b0001110, 5'd7, 5'd7, 5'd0, 6'b110001, 2'd3);
    tbl[4]  = mk(7'b0001100, 5'd7, 5'd7, 5'd7, 6'b000000, 2'd0);
    tbl[5]  = mk(7'b0001010, 5'd7, 5'd7, 5'd0, 6'b000000, 2'd0);
    tbl[6]  = mk(7'b0000110, 5'd7, 5'd7, 5'd0, 6'b000000, 2'd0);
    tbl[7]  = mk(7'b0010000, 5'd0, 5'd0, 5'd0, 6'b100010, 2'd0);
    tbl[8]  = mk(7'b0011101, 5'd9, 5'd0, 5'd9, 6'b110001, 2'd3);
    tbl[9]  = mk(7'b0100000, 5'd0, 5'd0, 5'd0, 6'b000011, 2'd2);
    tbl[10] = mk(7'b0111110, 5'd3, 5'd3, 5'd0, 6'b000011, 2'd2);
    tbl[11] = mk(7'b1000000, 5'd0, 5'd0, 5'd0, 6'b111100, 2'd1);
    tbl[12] = mk(7'b1111111, 5'd4, 5'd4, 5'd4, 6'b111100, 2'd1);
    tbl[13] = mk(7'b0001111, 5'd4, 5'd2, 5'd3, 6'b000000, 2'd0);

    rst = 1; idle();

    // Reset held three cycles, then released idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_a", 64'(a_out), 64'(6'b000011));
      chk("rst_out_b", 64'(b_out), 64'(6'b000011));
    end
    nxt(); rst = 0;
    @(negedge clk);
    chk("post_rst_out", 64'(a_out), 64'd0);
    chk("post_rst_state", 64'(a_state), 64'd0);
    chk("post_rst_sc", 64'(a_sc), 64'd0);
    chk("post_rst_fc", 64'(a_fc), 64'd0);

    // Load-use on rs2, then the same with rd=x0.
    nxt(); ld = 1; we = 1; rd = 5'd5; rs2 = 5'd5; u2 = 1;
    @(negedge clk);
    chk("lu_out", 64'(a_out), 64'(6'b110001));
    chk("lu_stallEXMEM", 64'(a_sexmem), 64'd0);
    nxt(); idle();
    @(negedge clk);
    chk("lu_state", 64'(a_state), 64'd3);
    chk("lu_sc", 64'(a_sc), 64'd1);
    nxt(); ld = 1; we = 1; rd = 5'd0; rs2 = 5'd0; u2 = 1;
    @(negedge clk);
    chk("lu_x0_out", 64'(a_out), 64'd0);
    nxt(); idle();
    @(negedge clk);
    chk("lu_x0_state", 64'(a_state), 64'd0);
    chk("lu_x0_sc", 64'(a_sc), 64'd1);

    // Branch pulse: 3-cycle flush on A, 4-cycle on B.
    nxt(); pulse_reset(); br = 1;
    @(negedge clk);
    chk("br_c0_a", 64'(a_out), 64'(6'b000011));
    chk("br_c0_b", 64'(b_out), 64'(6'b000011));
    nxt(); br = 0;
    @(negedge clk);
    chk("br_c1_a", 64'(a_out), 64'(6'b000010));
    chk("br_c1_state", 64'(a_state), 64'd2);
    nxt();
    @(negedge clk);
    chk("br_c2_a", 64'(a_out), 64'(6'b000010));
    nxt();
    @(negedge clk);
    chk("br_c3_a", 64'(a_out), 64'd0);
    chk("br_c3_state", 64'(a_state), 64'd0);
    chk("br_c3_fc", 64'(a_fc), 64'd1);
    chk("br_c3_b", 64'(b_out), 64'(6'b000010));
    nxt();
    @(negedge clk);
    chk("br_c4_b", 64'(b_out), 64'd0);
    chk("br_c4_bstate", 64'(b_state), 64'd0);

    // Memory wait over a pending branch, then the branch is accepted.
    nxt(); pulse_reset(); mem = 1; br = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mw_out", 64'(a_out), 64'(6'b111100));
      if (i > 0) chk("mw_state", 64'(a_state), 64'd1);
      nxt();
    end
    mem = 0;
    @(negedge clk);
    chk("mw_rel_out", 64'(a_out), 64'(6'b000011));
    chk("mw_rel_sc", 64'(a_sc), 64'd4);
    nxt(); br = 0;
    @(negedge clk);
    chk("mw_fc", 64'(a_fc), 64'd1);
    chk("mw_after_state", 64'(a_state), 64'd2);
    chk("mw_after_sc", 64'(a_sc), 64'd4);

    // Reset in the middle of B's 4-cycle flush.
    nxt(); pulse_reset(); br = 1;
    nxt(); br = 0;
    nxt(); rst = 1;
    @(negedge clk);
    chk("rmid_rst_b", 64'(b_out), 64'(6'b000011));
    nxt(); rst = 0;
    @(negedge clk);
    chk("rmid_state_b", 64'(b_state), 64'd0);
    chk("rmid_out_b", 64'(b_out), 64'd0);
    nxt();
    @(negedge clk);
    chk("rmid_out2_b", 64'(b_out), 64'd0);

    // Single-cycle vectors from a clean RUN state.
    for (int i = 0; i < 14; i++) begin
      nxt(); pulse_reset();
      {mem, br, ifb, ld, we, u1, u2} = tbl[i].ctl;
      rd = tbl[i].rd; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), 64'(a_out), 64'(tbl[i].eo));
      nxt(); idle();
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 64'(a_state), 64'(tbl[i].es));
    end

    // Random traffic; memory waits only start outside flush sequences.
    nxt(); pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      mem = (m_rem[0] == 0 && m_rem[1] == 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
      br  = ($urandom_range(0, 7) == 0);
      ifb = ($urandom_range(0, 3) == 0);
      ld  = 1'($urandom_range(0, 1));
      we  = ($urandom_range(0, 3) != 0);
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      rd  = RAW'($urandom_range(0, 3));
      rs1 = RAW'($urandom_range(0, 3));
      rs2 = RAW'($urandom_range(0, 3));
      nxt();
    end
    rst = 0; idle();
    repeat (6) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
